branch_predictor: RTL and testbench

Fetch-side counterpart of the execute-stage branch resolver. Predicts direction and target for the fetch PC from a direct-mapped BTB plus a 2-bit bimodal history table. Consumes resolution results from execute, trains both tables, and emits a registered redirect to fetch on misprediction.

---
 rtl/branch_predictor_pkg.sv | 14 +
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor: default table depth
// and the 2-bit bimodal counter encodings.
package branch_predictor_pkg;

    localparam int BTB_ENTRIES_DEF = 64;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } bht_state_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter, used to compute
// the BHT write value from the current entry and the resolved direction.
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       up,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cnt;
        if (up) begin
            if (cnt != 2'(STRONG_T)) nxt = cnt + 2'd1;
        end else begin
            if (cnt != 2'(STRONG_NT)) nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus untagged bimodal BHT. Predicts for fetch_pc
// combinationally, trains from execute results, and registers a redirect on mispredict.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_is_cond,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [ADDR_WIDTH-1:0] target;
        logic                  is_cond;
    } btb_entry_t;

    btb_entry_t btb [BTB_ENTRIES];
    logic [1:0] bht [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX-1:0]   u_idx;
    logic [TAG_W-1:0] u_tag;
    btb_entry_t       f_ent;
    logic             f_hit;
    logic             mispredict;
    logic [1:0]       bht_nxt;

    assign f_idx = fetch_pc[IDX+1:2];
    assign f_tag = fetch_pc[ADDR_WIDTH-1:IDX+2];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[ADDR_WIDTH-1:IDX+2];

    // Reads see the tables as they stood before this cycle's training write.
    assign f_ent       = btb[f_idx];
    assign f_hit       = f_ent.valid && (f_ent.tag == f_tag);
    assign pred_taken  = f_hit && (!f_ent.is_cond || bht[f_idx][1]);
    assign pred_target = pred_taken ? f_ent.target : fetch_pc + ADDR_WIDTH'(4);

    // upd_valid qualifies every upd_* field for exactly one cycle; there is no
    // back-pressure, so each valid cycle is consumed on the following edge.
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    branch_predictor_sat_counter2 u_sat (
        .cnt (bht[u_idx]),
        .up  (upd_taken),
        .nxt (bht_nxt)
    );

    // Only the valid bits are cleared; tag/target are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb[i].valid <= 1'b0;
        end else if (upd_valid && upd_taken) begin
            btb[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, is_cond: upd_is_cond};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) bht[i] <= WEAK_NT;
        end else if (upd_valid && upd_is_cond) begin
            bht[u_idx] <= bht_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= upd_taken ? upd_target : upd_pc + ADDR_WIDTH'(4);
                if (mispredict_count != '1) mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level reference model checked
// every cycle, plus literal expectations taken from hand-worked scenarios.
module tb_branch_predictor;

    localparam int AW = 32;
    localparam int N  = 64;
    localparam int CW = 16;
    localparam int CNT_MAX = 65535;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] fetch_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_is_cond;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [CW-1:0] mispredict_count;

    branch_predictor #(.ADDR_WIDTH(AW), .BTB_ENTRIES(N), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_cond      (upd_is_cond),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mispredict_count (mispredict_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW-1:0] exp_q[$];
    bit            m_valid  [N];
    logic [AW-1:0] m_tag    [N];
    logic [AW-1:0] m_target [N];
    bit            m_cond   [N];
    int            m_hist   [N];
    bit            m_rv;
    logic [AW-1:0] m_rpc;
    int            m_mis;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_hist[i]  = 1;
        end
        m_rv  = 1'b0;
        m_rpc = '0;
        m_mis = 0;
        exp_q.delete();
    endfunction

    always @(posedge clk) begin
        bit            mis;
        int            i;
        if (rst) begin
            model_reset();
        end else begin
            mis = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && upd_target != upd_pred_target));
            m_rv = mis;
            if (mis) begin
                m_rpc = upd_taken ? upd_target : upd_pc + 32'd4;
                exp_q.push_back(m_rpc);
                if (m_mis < CNT_MAX) m_mis++;
            end
            if (upd_valid) begin
                i = int'((upd_pc / 4) % N);
                if (upd_taken) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = upd_pc / (4 * N);
                    m_target[i] = upd_target;
                    m_cond[i]   = upd_is_cond;
                end
                if (upd_is_cond) begin
                    if (upd_taken) m_hist[i] = (m_hist[i] >= 3) ? 3 : m_hist[i] + 1;
                    else           m_hist[i] = (m_hist[i] <= 0) ? 0 : m_hist[i] - 1;
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        int            i;
        bit            hit;
        bit            tk;
        logic [AW-1:0] tgt;
        logic [AW-1:0] e;
        if (chk_en) begin
            i   = int'((fetch_pc / 4) % N);
            hit = m_valid[i] && (m_tag[i] == fetch_pc / (4 * N));
            tk  = hit && (!m_cond[i] || m_hist[i] >= 2);
            tgt = tk ? m_target[i] : fetch_pc + 32'd4;
            chk("pred_taken", pred_taken, tk);
            chk("pred_target", pred_target, tgt);
            chk("redirect_valid", redirect_valid, m_rv);
            chk("mispredict_count", mispredict_count, m_mis);
            if (m_rv) begin
                chk("redirect_queue_depth", 32'(exp_q.size()), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("redirect_pc", redirect_pc, e);
                end
            end else begin
                chk("redirect_pc_hold", redirect_pc, m_rpc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_upd(input logic [AW-1:0] pc, input logic cond, input logic tk,
                             input logic [AW-1:0] tgt, input logic ptk, input logic [AW-1:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_is_cond     = cond;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic lookup_check(input string name, input logic [AW-1:0] pc,
                                input logic exp_tk, input logic [AW-1:0] exp_tgt);
        fetch_pc = pc;
        @(negedge clk);
        chk({name, "_taken"}, pred_taken, exp_tk);
        chk({name, "_target"}, pred_target, exp_tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_check(input string name, input logic exp_v, input logic [AW-1:0] exp_pc);
        @(negedge clk);
        chk({name, "_valid"}, redirect_valid, exp_v);
        chk({name, "_pc"}, redirect_pc, exp_pc);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst             = 1'b1;
        fetch_pc        = 32'h100;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_is_cond     = 1'b0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        idle(2);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_count", mispredict_count, 0);
        @(posedge clk);
        #1;
        redirect_check("reset_redirect", 1'b0, 32'h0);
        lookup_check("reset_lookup", 32'h100, 1'b0, 32'h104);

        // First taken conditional: mispredict, then hit with counter 2
        drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        redirect_check("first_train", 1'b1, 32'h80);
        lookup_check("trained_hit", 32'h100, 1'b1, 32'h80);

        // Counter 2 -> 1 -> 0, then saturates at 0
        drive_upd(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        redirect_check("nt_mispredict", 1'b1, 32'h104);
        drive_upd(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104);
        lookup_check("cnt0_lookup", 32'h100, 1'b0, 32'h104);
        drive_upd(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104);
        lookup_check("cnt_sat0", 32'h100, 1'b0, 32'h104);
        drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        lookup_check("cnt_sat0_plus1", 32'h100, 1'b0, 32'h104);

        // JAL: train, correct prediction, then target change
        drive_upd(32'h200, 1'b0, 1'b1, 32'h400, 1'b0, 32'h204);
        lookup_check("jal_hit", 32'h200, 1'b1, 32'h400);
        drive_upd(32'h200, 1'b0, 1'b1, 32'h400, 1'b1, 32'h400);
        redirect_check("jal_correct", 1'b0, 32'h400);
        drive_upd(32'h200, 1'b0, 1'b1, 32'h500, 1'b1, 32'h400);
        redirect_check("jal_new_target", 1'b1, 32'h500);

        // Alias: 0x100 and 0x100 + 4*N share index 0
        drive_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
        lookup_check("alias_before", 32'h100, 1'b1, 32'h80);
        drive_upd(32'h100 + 4 * N, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204);
        lookup_check("alias_evicted", 32'h100, 1'b0, 32'h104);
        lookup_check("alias_owner", 32'h100 + 4 * N, 1'b1, 32'h300);

        // Back-to-back mispredicts, reset on the second
        fetch_pc        = 32'h300;
        upd_valid       = 1'b1;
        upd_pc          = 32'h300;
        upd_is_cond     = 1'b0;
        upd_taken       = 1'b1;
        upd_target      = 32'h700;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h304;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        upd_pc     = 32'h304;
        upd_target = 32'h900;
        @(negedge clk);
        chk("prereset_pulse_valid", redirect_valid, 1'b1);
        chk("prereset_pulse_pc", redirect_pc, 32'h700);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        @(negedge clk);
        chk("rst_drop_valid", redirect_valid, 1'b0);
        chk("rst_drop_pc", redirect_pc, 32'h0);
        chk("rst_count", mispredict_count, 0);
        chk("rst_lookup_taken", pred_taken, 1'b0);
        chk("rst_lookup_target", pred_target, 32'h304);
        @(posedge clk);
        #1;

        // Saturate the mispredict counter
        fetch_pc        = 32'h100;
        upd_valid       = 1'b1;
        upd_pc          = 32'h100;
        upd_is_cond     = 1'b0;
        upd_taken       = 1'b1;
        upd_target      = 32'h80;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h104;
        repeat ((1 << CW) + 3) @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        chk("count_saturated", mispredict_count, 32'hFFFF);
        chk("sat_last_pc", redirect_pc, 32'h80);
        @(posedge clk);
        #1;
        idle(2);
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
